// File: rtl/ls163_param_counter.sv
// Synchronous presettable binary counter in the 74LS163/74LS169 style,
// parametrised over width, modulus and up/down capability, cascadable via enp/ent/rco.
module ls163_param_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter bit     UPDOWN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam longint           TERM_L = MODULUS - 64'sd1;
    localparam logic [WIDTH-1:0] TERM   = TERM_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q_s;
    logic             dir_s;
    logic             count_en_s;

    assign dir_s      = UPDOWN ? up : 1'b1;
    assign count_en_s = enp & ent;

    // Next-state selection: load over count over hold; clear is applied in the register.
    always_comb begin
        next_q_s = q_r;
        if (!load_n) begin
            next_q_s = d;
        end else if (count_en_s) begin
            if (dir_s) begin
                // Out-of-range values (after a load of d >= MODULUS) also wrap to zero.
                next_q_s = (q_r >= TERM) ? ZERO : (q_r + ONE);
            end else begin
                next_q_s = (q_r == ZERO) ? TERM : (q_r - ONE);
            end
        end else begin
            next_q_s = q_r;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= ZERO;
        end else begin
            q_r <= next_q_s;
        end
    end

    assign q   = q_r;
    // Terminal count depends on direction; left combinational so cascades add no latency.
    assign rco = ent & (dir_s ? (q_r == TERM) : (q_r == ZERO));

endmodule

// File: tb/tb_ls163_param_counter.sv
// Directed self-checking bench: a WIDTH=4/MODULUS=10 counter plus a two-stage
// WIDTH=4/MODULUS=16 cascade acting as an 8-bit counter.
module tb_ls163_param_counter;

    logic       clk;
    logic       rst_n, load_n, enp, ent, up;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    logic       c_rst_n, c_enp;
    logic [3:0] q_lo, q_hi;
    logic       rco_lo, rco_hi;

    int n_checks;
    int n_pass;

    ls163_param_counter #(.WIDTH(4), .MODULUS(10), .UPDOWN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .enp(enp), .ent(ent),
        .up(up), .d(d), .q(q), .rco(rco)
    );

    ls163_param_counter #(.WIDTH(4), .MODULUS(16), .UPDOWN(1'b1)) u_lo (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .enp(c_enp), .ent(1'b1),
        .up(1'b1), .d(4'd0), .q(q_lo), .rco(rco_lo)
    );

    ls163_param_counter #(.WIDTH(4), .MODULUS(16), .UPDOWN(1'b1)) u_hi (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .enp(c_enp), .ent(rco_lo),
        .up(1'b1), .d(4'd0), .q(q_hi), .rco(rco_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset with load and count also requested
        rst_n = 1'b0; load_n = 1'b0; d = 4'hA; enp = 1'b1; ent = 1'b1; up = 1'b1;
        c_rst_n = 1'b0; c_enp = 1'b0;
        step();
        check_eq("reset_q", {4'd0, q}, 8'd0);
        check_eq("reset_rco_up", {7'd0, rco}, 8'd0);
        check_eq("reset_cascade", {q_hi, q_lo}, 8'd0);
        step();
        check_eq("reset_q2", {4'd0, q}, 8'd0);
        up = 1'b0;
        #1;
        check_eq("reset_rco_down", {7'd0, rco}, 8'd1);
        up = 1'b1;
        c_rst_n = 1'b1;

        // Up count 1..9
        rst_n = 1'b1; load_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check_eq("up_q", {4'd0, q}, 8'(i));
            check_eq("up_rco", {7'd0, rco}, (i == 9) ? 8'd1 : 8'd0);
        end
        ent = 1'b0;
        #1;
        check_eq("ent0_rco", {7'd0, rco}, 8'd0);
        step();
        check_eq("ent0_hold", {4'd0, q}, 8'd9);
        ent = 1'b1;
        #1;
        check_eq("ent1_rco", {7'd0, rco}, 8'd1);
        step();
        check_eq("up_wrap", {4'd0, q}, 8'd0);

        // Down count with wrap
        load_n = 1'b0; d = 4'd2;
        step();
        check_eq("load2", {4'd0, q}, 8'd2);
        load_n = 1'b1; up = 1'b0;
        step();
        check_eq("down_1", {4'd0, q}, 8'd1);
        check_eq("down_rco_1", {7'd0, rco}, 8'd0);
        step();
        check_eq("down_0", {4'd0, q}, 8'd0);
        check_eq("down_rco_0", {7'd0, rco}, 8'd1);
        up = 1'b1;
        #1;
        check_eq("flip_rco", {7'd0, rco}, 8'd0);
        up = 1'b0;
        step();
        check_eq("down_wrap", {4'd0, q}, 8'd9);
        check_eq("down_rco_9", {7'd0, rco}, 8'd0);

        // Priority: load beats count, reset beats load, enp gates count
        up = 1'b1; load_n = 1'b0; d = 4'd7;
        step();
        check_eq("load_no_inc", {4'd0, q}, 8'd7);
        rst_n = 1'b0; d = 4'd3;
        step();
        check_eq("rst_over_load", {4'd0, q}, 8'd0);
        rst_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("enp0_hold", {4'd0, q}, 8'd0);
        end
        enp = 1'b1;

        // Out-of-range load
        load_n = 1'b0; d = 4'd13;
        step();
        check_eq("load13", {4'd0, q}, 8'd13);
        check_eq("rco13", {7'd0, rco}, 8'd0);
        load_n = 1'b1; up = 1'b1;
        step();
        check_eq("oor_up", {4'd0, q}, 8'd0);
        load_n = 1'b0;
        step();
        load_n = 1'b1; up = 1'b0;
        step();
        check_eq("oor_down", {4'd0, q}, 8'd12);
        step();
        check_eq("oor_down2", {4'd0, q}, 8'd11);

        // Cascade: 256 up edges on the 8-bit pair
        check_eq("casc_start", {q_hi, q_lo}, 8'd0);
        c_enp = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            check_eq("casc_q", {q_hi, q_lo}, 8'(i % 256));
            check_eq("casc_rco", {7'd0, rco_hi}, (i == 255) ? 8'd1 : 8'd0);
        end
        c_enp = 1'b0;
        step();
        check_eq("casc_hold", {q_hi, q_lo}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ls163_param_counter.md
Name: ls163_param_counter

Overview:
- Parametrised successor to the fixed-function 74-series gate models: a synchronous, presettable, cascadable binary counter in the 74LS163/74LS169 style.
- Generalised over width and modulus, with selectable up/down direction.
- Used as the standard counter primitive in the 74-series logic library.
- Cascades through its enp/ent/rco chain exactly as the discrete parts do.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MODULUS, 16, count length; the terminal value when counting up is MODULUS-1 (legal range 2..2^WIDTH).
- UPDOWN, 1, direction select: 1 = up input honoured; 0 = up input ignored and counter is up-only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low clear (74LS163 CLR semantics).
- load_n  input  1  synchronous active-low parallel load.
- enp  input  1  count enable P.
- ent  input  1  count enable T; also gates rco.
- up  input  1  direction: 1 = up, 0 = down (ignored when UPDOWN=0).
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  registered count.
- rco  output  1  ripple carry out, combinational.

Behaviour:
- One clock; reset is synchronous and active-low. rst_n is sampled only on the rising edge of clk. There is no asynchronous path.
- Priority at each rising edge is rst_n, then load_n, then count, then hold:
  - rst_n=0: q <= 0, regardless of load_n, enp and ent.
  - Otherwise load_n=0: q <= d, regardless of enp and ent.
  - Otherwise enp=1 and ent=1: count one step in the effective direction.
  - Otherwise: q holds.
- Effective direction: dir = UPDOWN ? up : 1.
- Up step:
  - q <= 0 if q >= MODULUS-1.
  - Else q <= q+1.
- Down step:
  - q <= MODULUS-1 if q == 0.
  - Else q <= q-1.
- Out-of-range load:
  - d >= MODULUS is loaded verbatim.
  - The next up step goes to 0.
  - A down step decrements normally until the value is back in range.
- Arithmetic stays within WIDTH bits; there is no overflow beyond WIDTH.
- rco = ent & (dir ? (q == MODULUS-1) : (q == 0)).
  - rco is purely combinational from q, ent and up, and is independent of enp, load_n and rst_n.
  - rco is glitch-free only to the extent that its inputs are registered.
- Latency:
  - Every q change is visible 1 clock after the qualifying edge.
  - rco follows q and ent in the same cycle (zero latency).
- Cascade rule: stage k+1 takes ent from rco of stage k, and every stage shares enp. A WIDTH=4 pair cascaded this way behaves as an 8-bit counter with no extra latency.
- Reset state: q = 0. rco = ent & !dir after reset (q==0 is terminal when counting down).
- Reset mid-operation: rst_n=0 on any edge clears q that edge. A load or count requested on the same edge is discarded.
- Direction change mid-count takes effect on the next counting edge. rco re-evaluates immediately.
- Simultaneous load_n=0 with enp=ent=1: the load wins and no count is applied to d.
- X/Z on any input when sampled is outside this specification. The bench drives only 0/1.

Test Plan:
- Reset: rst_n=0 for 2 clocks with load_n=0, d=4'hA, enp=ent=1 -> q=0 after the first edge; rco=0 with up=1.
- Up count, WIDTH=4, MODULUS=10: from q=0 with enp=ent=1, up=1, apply 10 edges -> q sequence 1..9,0. rco=1 only while q=9; with ent=0 at q=9, rco=0 and q holds.
- Down/wrap, MODULUS=10: load d=2, then 3 down edges -> q=1,0,9. rco=1 while q=0 and up=0. Flipping up=1 at q=0 gives rco=0 in the same cycle.
- Priority: rst_n=1, load_n=0, d=7, enp=ent=1 -> q=7 (no increment). Next edge, rst_n=0 with load_n=0, d=3 -> q=0. Then enp=0, ent=1 for 5 edges -> q holds at 0.
- Out-of-range load, WIDTH=4, MODULUS=10: load d=13, one up edge -> q=0. Load d=13, one down edge -> q=12.
- Cascade: two WIDTH=4, MODULUS=16 instances, the low stage's rco feeding the high stage's ent. From 8'h00, 256 up edges -> concatenated q walks 8'h01..8'hFF,8'h00. The high-stage rco=1 only at 8'hFF.
